// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared state encodings and access-direction constants
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_PL  = 2'd1,
        RD_DBG = 2'd2
    } state_t;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - pipeline, debug and data-memory port bundle of the arbiter
interface dmem_arbiter_if #(
    parameter int IO_BUS_SIZE   = 32,
    parameter int MEM_ADDR_SIZE = 5
);
    logic                     i_pl_req;
    logic                     i_pl_wr_rd;
    logic [MEM_ADDR_SIZE-1:0] i_pl_addr;
    logic [IO_BUS_SIZE-1:0]   i_pl_data;
    logic                     o_pl_gnt;
    logic                     o_pl_stall;
    logic [IO_BUS_SIZE-1:0]   o_pl_rd_data;
    logic                     o_pl_rd_valid;

    logic                     i_dbg_req;
    logic                     i_dbg_wr_rd;
    logic [MEM_ADDR_SIZE-1:0] i_dbg_addr;
    logic [IO_BUS_SIZE-1:0]   i_dbg_data;
    logic                     o_dbg_gnt;
    logic [IO_BUS_SIZE-1:0]   o_dbg_rd_data;
    logic                     o_dbg_rd_valid;

    logic                     o_mem_wr_rd;
    logic [MEM_ADDR_SIZE-1:0] o_mem_addr;
    logic [IO_BUS_SIZE-1:0]   o_mem_data;
    logic [IO_BUS_SIZE-1:0]   i_mem_data;

    // Arbiter side
    modport slave (
        input  i_pl_req, i_pl_wr_rd, i_pl_addr, i_pl_data,
        output o_pl_gnt, o_pl_stall, o_pl_rd_data, o_pl_rd_valid,
        input  i_dbg_req, i_dbg_wr_rd, i_dbg_addr, i_dbg_data,
        output o_dbg_gnt, o_dbg_rd_data, o_dbg_rd_valid,
        output o_mem_wr_rd, o_mem_addr, o_mem_data,
        input  i_mem_data
    );

    // Requesters and memory side
    modport master (
        output i_pl_req, i_pl_wr_rd, i_pl_addr, i_pl_data,
        input  o_pl_gnt, o_pl_stall, o_pl_rd_data, o_pl_rd_valid,
        output i_dbg_req, i_dbg_wr_rd, i_dbg_addr, i_dbg_data,
        input  o_dbg_gnt, o_dbg_rd_data, o_dbg_rd_valid,
        input  o_mem_wr_rd, o_mem_addr, o_mem_data,
        output i_mem_data
    );
endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// rtl/dmem_arbiter_starve_counter.sv - saturating count of pipeline wins while debug waits
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 4'd0;
        end else if (inc && (count != LIM)) begin
            count <= count + 4'd1;
        end
    end

    assign at_limit = (count == LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - arbitrates pipeline and debug accesses onto one data-memory port
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int IO_BUS_SIZE   = 32,
    parameter int MEM_ADDR_SIZE = 5,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_flush,
    dmem_arbiter_if.slave bus
);
    logic                     pl_gnt;
    logic                     dbg_gnt;
    logic                     starve_hit;
    logic                     mem_wr_rd;
    logic [MEM_ADDR_SIZE-1:0] mem_addr;
    logic [IO_BUS_SIZE-1:0]   mem_data;
    state_t                   state;

    // Pipeline has priority unless debug has waited out the starve limit
    always_comb begin
        dbg_gnt = !i_reset && bus.i_dbg_req && (!bus.i_pl_req || starve_hit);
        pl_gnt  = !i_reset && bus.i_pl_req && !(bus.i_dbg_req && starve_hit);
    end

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (i_clk),
        .rst      (i_reset),
        .clr      (dbg_gnt || !bus.i_dbg_req),
        .inc      (pl_gnt && bus.i_dbg_req),
        .at_limit (starve_hit)
    );

    always_comb begin
        mem_wr_rd = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        if (pl_gnt) begin
            mem_wr_rd = bus.i_pl_wr_rd;
            mem_addr  = bus.i_pl_addr;
            mem_data  = bus.i_pl_data;
        end else if (dbg_gnt) begin
            mem_wr_rd = bus.i_dbg_wr_rd;
            mem_addr  = bus.i_dbg_addr;
            mem_data  = bus.i_dbg_data;
        end
    end

    assign bus.o_pl_gnt    = pl_gnt;
    assign bus.o_dbg_gnt   = dbg_gnt;
    assign bus.o_pl_stall  = bus.i_pl_req && !pl_gnt;
    assign bus.o_mem_wr_rd = mem_wr_rd;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_data  = mem_data;

    // Tracks whose read data arrives on i_mem_data in the following cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else if (pl_gnt && (bus.i_pl_wr_rd == RD) && !i_flush) begin
            state <= RD_PL;
        end else if (dbg_gnt && (bus.i_dbg_wr_rd == RD)) begin
            state <= RD_DBG;
        end else begin
            state <= IDLE;
        end
    end

    // Reset squashes a response already in flight in the reset cycle itself
    assign bus.o_pl_rd_valid  = (state == RD_PL)  && !i_reset;
    assign bus.o_dbg_rd_valid = (state == RD_DBG) && !i_reset;
    assign bus.o_pl_rd_data   = bus.o_pl_rd_valid  ? bus.i_mem_data : '0;
    assign bus.o_dbg_rd_data  = bus.o_dbg_rd_valid ? bus.i_mem_data : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    localparam int LIMIT = 4;

    logic clk;
    logic rst;
    logic flush;
    logic init_mem;

    int errors = 0;
    int checks = 0;

    dmem_arbiter_if #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(5)) bus ();

    dmem_arbiter #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(5), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_flush (flush),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return 32'hA500_0000 ^ (i * 32'h0101_0101);
    endfunction

    // Data memory: one-cycle read latency, read returns pre-write contents
    logic [31:0] mem [32];
    logic [31:0] mem_q;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            mem_q <= 32'h0;
        end else begin
            mem_q <= mem[bus.o_mem_addr];
            if (bus.o_mem_wr_rd) mem[bus.o_mem_addr] <= bus.o_mem_data;
        end
    end
    assign bus.i_mem_data = mem_q;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int          scnt = 0;
    bit          pend_pl = 0, pend_dbg = 0;
    logic [31:0] pend_pl_data = 0, pend_dbg_data = 0;
    logic [31:0] shadow [32];
    bit          m_pl_gnt = 0, m_dbg_gnt = 0;
    bit          e_pg, e_dg, e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    always @(negedge clk) begin
        if (!init_mem) begin
            e_dg = !rst && bus.i_dbg_req && (!bus.i_pl_req || scnt == LIMIT);
            e_pg = !rst && bus.i_pl_req && !e_dg;
            e_wr = 0; e_addr = 0; e_data = 0;
            if (e_pg) begin
                e_wr = bus.i_pl_wr_rd; e_addr = bus.i_pl_addr; e_data = bus.i_pl_data;
            end else if (e_dg) begin
                e_wr = bus.i_dbg_wr_rd; e_addr = bus.i_dbg_addr; e_data = bus.i_dbg_data;
            end
            chk("pl_gnt", bus.o_pl_gnt, e_pg);
            chk("dbg_gnt", bus.o_dbg_gnt, e_dg);
            chk("pl_stall", bus.o_pl_stall, bus.i_pl_req && !e_pg);
            chk("mem_wr_rd", bus.o_mem_wr_rd, e_wr);
            chk("mem_addr", bus.o_mem_addr, e_addr);
            chk("mem_data", bus.o_mem_data, e_data);
            chk("pl_rd_valid", bus.o_pl_rd_valid, pend_pl && !rst);
            chk("pl_rd_data", bus.o_pl_rd_data, (pend_pl && !rst) ? pend_pl_data : 32'h0);
            chk("dbg_rd_valid", bus.o_dbg_rd_valid, pend_dbg && !rst);
            chk("dbg_rd_data", bus.o_dbg_rd_data, (pend_dbg && !rst) ? pend_dbg_data : 32'h0);

            pend_pl  = e_pg && !e_wr && !flush;
            pend_dbg = e_dg && !e_wr;
            pend_pl_data  = shadow[e_addr];
            pend_dbg_data = shadow[e_addr];
            if (e_wr) shadow[e_addr] = e_data;
            if (rst || !bus.i_dbg_req || e_dg) scnt = 0;
            else if (e_pg && scnt < LIMIT) scnt = scnt + 1;
            m_pl_gnt  = e_pg;
            m_dbg_gnt = e_dg;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_pl_req = 0; bus.i_pl_wr_rd = 0; bus.i_pl_addr = 0; bus.i_pl_data = 0;
        bus.i_dbg_req = 0; bus.i_dbg_wr_rd = 0; bus.i_dbg_addr = 0; bus.i_dbg_data = 0;
        flush = 0;
    endtask

    task automatic pl(logic wr, logic [4:0] a, logic [31:0] d);
        bus.i_pl_req = 1; bus.i_pl_wr_rd = wr; bus.i_pl_addr = a; bus.i_pl_data = d;
    endtask

    task automatic dbg(logic wr, logic [4:0] a, logic [31:0] d);
        bus.i_dbg_req = 1; bus.i_dbg_wr_rd = wr; bus.i_dbg_addr = a; bus.i_dbg_data = d;
    endtask

    int bad;

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
        rst = 1; init_mem = 1;
        idle();
        repeat (2) @(posedge clk);
        #1 init_mem = 0;
        pl(1, 3, 32'h1111_1111); dbg(0, 2, 0);
        @(negedge clk);
        chk("reset_pl_gnt", bus.o_pl_gnt, 0);
        chk("reset_mem_wr", bus.o_mem_wr_rd, 0);
        chk("reset_pl_valid", bus.o_pl_rd_valid, 0);
        step();
        rst = 0; idle();

        // write then read back through the pipeline port
        pl(1, 3, 32'hDEAD_BEEF);
        @(negedge clk); chk("wr3_gnt", bus.o_pl_gnt, 1); chk("wr3_mem_wr", bus.o_mem_wr_rd, 1);
        step(); pl(0, 3, 0);
        @(negedge clk); chk("rd3_gnt", bus.o_pl_gnt, 1);
        step(); idle();
        @(negedge clk); chk("rd3_valid", bus.o_pl_rd_valid, 1); chk("rd3_data", bus.o_pl_rd_data, 32'hDEAD_BEEF);
        step();

        // starvation: four pipeline wins then one debug win, repeating
        pl(0, 4, 0); dbg(0, 5, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("starve_pl_gnt", bus.o_pl_gnt, (c % 5) != 4);
            chk("starve_dbg_gnt", bus.o_dbg_gnt, (c % 5) == 4);
            chk("starve_stall", bus.o_pl_stall, (c % 5) == 4);
            step();
        end
        idle(); @(negedge clk); step();

        // flushed pipeline read, then debug read
        pl(0, 7, 0); flush = 1;
        @(negedge clk); chk("flush_gnt", bus.o_pl_gnt, 1);
        step(); idle(); dbg(0, 1, 0);
        @(negedge clk); chk("flush_no_valid", bus.o_pl_rd_valid, 0); chk("flush_dbg_gnt", bus.o_dbg_gnt, 1);
        step(); idle();
        @(negedge clk); chk("flush_dbg_valid", bus.o_dbg_rd_valid, 1); chk("flush_dbg_data", bus.o_dbg_rd_data, 32'hA401_0101);
        step();

        // back-to-back debug then pipeline reads
        dbg(0, 1, 0);
        @(negedge clk); step(); idle(); pl(0, 2, 0);
        @(negedge clk);
        chk("b2b_dbg_valid", bus.o_dbg_rd_valid, 1); chk("b2b_dbg_data", bus.o_dbg_rd_data, 32'hA401_0101);
        chk("b2b_pl_valid0", bus.o_pl_rd_valid, 0);
        step(); idle();
        @(negedge clk);
        chk("b2b_pl_valid", bus.o_pl_rd_valid, 1); chk("b2b_pl_data", bus.o_pl_rd_data, 32'hA702_0202);
        chk("b2b_dbg_valid0", bus.o_dbg_rd_valid, 0);
        step();

        // write to the same address during the read response
        pl(0, 9, 0);
        @(negedge clk); step(); idle(); dbg(1, 9, 32'h1234_5678);
        @(negedge clk);
        chk("rw_pl_valid", bus.o_pl_rd_valid, 1); chk("rw_old_data", bus.o_pl_rd_data, 32'hAC09_0909);
        chk("rw_dbg_gnt", bus.o_dbg_gnt, 1);
        step(); idle(); dbg(0, 9, 0);
        @(negedge clk); step(); idle();
        @(negedge clk); chk("rw_new_data", bus.o_dbg_rd_data, 32'h1234_5678);
        step();

        // reset in the cycle after a debug read grant
        dbg(0, 5, 0);
        @(negedge clk); chk("rst_dbg_gnt", bus.o_dbg_gnt, 1);
        step(); rst = 1; pl(0, 6, 0);
        @(negedge clk);
        chk("rst_dbg_valid", bus.o_dbg_rd_valid, 0); chk("rst_dbg_data", bus.o_dbg_rd_data, 0);
        chk("rst_gnt", {bus.o_pl_gnt, bus.o_dbg_gnt}, 0); chk("rst_mem_addr", bus.o_mem_addr, 0);
        step(); rst = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_dbg_valid", bus.o_dbg_rd_valid, 0);
            chk("post_rst_pl_gnt", bus.o_pl_gnt, c < 4);
            chk("post_rst_dbg_gnt", bus.o_dbg_gnt, c == 4);
            step();
        end
        idle();

        // randomized traffic; requesters hold fields until granted
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 4) == 0);
            if (!bus.i_pl_req || m_pl_gnt) begin
                bus.i_pl_req = ($urandom_range(0, 9) < 6);
                bus.i_pl_wr_rd = 1'($urandom_range(0, 1));
                bus.i_pl_addr = 5'($urandom_range(0, 7));
                bus.i_pl_data = $urandom;
            end
            if (!bus.i_dbg_req || m_dbg_gnt) begin
                bus.i_dbg_req = ($urandom_range(0, 9) < 5);
                bus.i_dbg_wr_rd = 1'($urandom_range(0, 1));
                bus.i_dbg_addr = 5'($urandom_range(0, 7));
                bus.i_dbg_data = $urandom;
            end
            step();
        end
        rst = 0; idle();

        // idle bus issues no writes and leaves memory intact
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); chk("idle_mem_wr", bus.o_mem_wr_rd, 0);
            step();
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== shadow[i]) bad++;
        chk("mem_contents_bad_words", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
